// File: rtl/event_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : event_serializer_if
//  Purpose  : FIFO write-side bundle between the event serializer and a
//             downstream FIFO (write strobe, write data, full flag).
//  Revision : 1.0 - initial release
// ============================================================================
interface event_serializer_if #(
    parameter int WORD_W = 64
);
    logic              full_i;
    logic              wr_en_o;
    logic [WORD_W-1:0] din_o;

    modport master (input full_i, output wr_en_o, output din_o);
    modport slave  (output full_i, input wr_en_o, input din_o);
endinterface
`default_nettype wire

// File: rtl/event_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : event_serializer
//  Purpose  : Captures a wide asynchronous event vector on the rising edge of
//             a synchronised ready level and streams it word by word into a
//             FIFO, optionally preceded by a header word carrying counters.
//  Revision : 1.0 - initial release
// ============================================================================
module event_serializer #(
    parameter int WORD_W    = 64,
    parameter int N_WORDS   = 16,
    parameter int HEADER_EN = 1
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic [N_WORDS*WORD_W-1:0] event_i,
    input  logic                      event_ready_i,
    event_serializer_if.master        fifo,
    output logic                      event_saved_o,
    output logic                      busy_o,
    output logic [31:0]               evt_count_o,
    output logic [15:0]               drop_count_o
);
    localparam int                 EVT_W    = N_WORDS * WORD_W;
    localparam int                 IDX_W    = $clog2(N_WORDS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                rdy_meta, rdy_sync, rdy_prev;
    logic [2:0]          vld;
    logic                start;
    logic [EVT_W-1:0]    ev_d1, ev_d2, shadow;
    logic                load;
    logic                wr_en_reg, wr_en_nxt;
    logic [WORD_W-1:0]   din_reg, din_nxt;
    logic                saved_reg, saved_nxt;
    logic [WORD_W-1:0]   header;
    logic [31:0]         evt_cnt;
    logic [15:0]         drop_cnt;

    // Ready synchroniser and edge detector; vld marks stages that hold real
    // post-reset samples so a level held high through reset is not an edge.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_meta <= 1'b0;
            rdy_sync <= 1'b0;
            rdy_prev <= 1'b0;
            vld      <= '0;
        end else begin
            rdy_meta <= event_ready_i;
            rdy_sync <= rdy_meta;
            rdy_prev <= rdy_sync;
            vld      <= {vld[1:0], 1'b1};
        end
    end

    assign start = rdy_sync & ~rdy_prev & vld[2];

    // Two-stage event delay aligning the data with the synchronised start.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ev_d1 <= '0;
            ev_d2 <= '0;
        end else begin
            ev_d1 <= event_i;
            ev_d2 <= ev_d1;
        end
    end

    // Header word: counters in the low bits, a fixed marker above them.
    always_comb begin
        header        = '0;
        header[31:0]  = evt_cnt;
        header[47:32] = drop_cnt;
        header[63:48] = 16'hCAFE;
    end

    // FSM state and word index register.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic and next values of the registered FIFO outputs.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_en_nxt = 1'b0;
        din_nxt   = din_reg;
        saved_nxt = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = (HEADER_EN != 0) ? HEADER : PAYLOAD;
                end
            end
            HEADER: begin
                if (!fifo.full_i) begin
                    wr_en_nxt = 1'b1;
                    din_nxt   = header;
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!fifo.full_i) begin
                    wr_en_nxt = 1'b1;
                    din_nxt   = shadow[idx*WORD_W +: WORD_W];
                    if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                saved_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered FIFO outputs and the event shadow capture.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_en_reg <= 1'b0;
            din_reg   <= '0;
            saved_reg <= 1'b0;
            shadow    <= '0;
        end else begin
            wr_en_reg <= wr_en_nxt;
            din_reg   <= din_nxt;
            saved_reg <= saved_nxt;
            if (load) begin
                shadow <= ev_d2;
            end
        end
    end

    // Completed-event counter (wraps) and dropped-event counter (saturates).
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            evt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (state == DONE) begin
                evt_cnt <= evt_cnt + 32'd1;
            end
            if (start && (state != IDLE) && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign fifo.wr_en_o  = wr_en_reg;
    assign fifo.din_o    = din_reg;
    assign event_saved_o = saved_reg;
    assign busy_o        = (state != IDLE);
    assign evt_count_o   = evt_cnt;
    assign drop_count_o  = drop_cnt;
endmodule
`default_nettype wire

// File: tb/tb_event_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_event_serializer
//  Purpose  : Self-checking bench for event_serializer: expected FIFO words
//             are queued as events are driven and popped on each write.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_event_serializer;
    localparam int W  = 64;
    localparam int N  = 16;
    localparam int W2 = 96;
    localparam int N2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              aresetn;
    logic [N*W-1:0]    ev;
    logic              rdy;
    logic              saved, busy;
    logic [31:0]       evt_cnt;
    logic [15:0]       drop_cnt;

    logic [N2*W2-1:0]  ev2;
    logic              rdy2;
    logic              saved2, busy2;
    logic [31:0]       evt_cnt2;
    logic [15:0]       drop_cnt2;

    event_serializer_if #(.WORD_W(W))  fifo1 ();
    event_serializer_if #(.WORD_W(W2)) fifo2 ();

    event_serializer #(.WORD_W(W), .N_WORDS(N), .HEADER_EN(1)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .event_i       (ev),
        .event_ready_i (rdy),
        .fifo          (fifo1),
        .event_saved_o (saved),
        .busy_o        (busy),
        .evt_count_o   (evt_cnt),
        .drop_count_o  (drop_cnt)
    );

    event_serializer #(.WORD_W(W2), .N_WORDS(N2), .HEADER_EN(0)) dut2 (
        .clk           (clk),
        .aresetn       (aresetn),
        .event_i       (ev2),
        .event_ready_i (rdy2),
        .fifo          (fifo2),
        .event_saved_o (saved2),
        .busy_o        (busy2),
        .evt_count_o   (evt_cnt2),
        .drop_count_o  (drop_cnt2)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] q[$];
    logic [31:0]  exp_evt  = '0;
    logic [15:0]  exp_drop = '0;

    function automatic logic [W-1:0] hdr(input logic [31:0] e, input logic [15:0] d);
        hdr = {16'hCAFE, d, e};
    endfunction

    function automatic logic [N*W-1:0] rand_evt();
        logic [N*W-1:0] v;
        for (int i = 0; i < N*W/32; i++) v[i*32 +: 32] = $urandom();
        rand_evt = v;
    endfunction

    task automatic push_event(input logic [N*W-1:0] v, input logic [31:0] e, input logic [15:0] d);
        q.push_back(hdr(e, d));
        for (int k = 0; k < N; k++) q.push_back(v[k*W +: W]);
    endtask

    // Raises ready before edge E and returns exactly at edge E.
    task automatic fire(input logic [N*W-1:0] v);
        @(negedge clk);
        @(negedge clk);
        ev  = v;
        rdy = 1'b1;
        @(posedge clk);
    endtask

    // Observes dut writes cycle by cycle relative to E, scoreboarding data.
    task automatic collect(input int c0, input int max_c, input int full_from, input int full_to,
                           input int pulse_at, input logic [N*W-1:0] nxt,
                           output int first_wr, output int last_wr, output int nwr,
                           output int saved_c, output int gap_wr, output logic [W-1:0] first_din);
        int           c;
        logic [W-1:0] exp;
        logic [W-1:0] prev_din;
        first_wr = -1; last_wr = -1; nwr = 0; saved_c = -1; gap_wr = 0; first_din = '0;
        prev_din = fifo1.din_o;
        c = c0;
        while (saved_c < 0 && c < max_c) begin
            @(posedge clk);
            #1;
            c++;
            if (fifo1.wr_en_o) begin
                if (first_wr < 0) begin
                    first_wr  = c;
                    first_din = fifo1.din_o;
                end
                last_wr = c;
                nwr++;
                if (c >= full_from && c <= full_to) gap_wr++;
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_extra_write: cycle %0d got %h expected no write", c, fifo1.din_o);
                end else begin
                    exp = q.pop_front();
                    if (fifo1.din_o !== exp) begin
                        n_fail++;
                        $display("FAIL din_word: cycle %0d got %h expected %h", c, fifo1.din_o, exp);
                    end
                end
            end
            if (c >= full_from && c <= full_to) begin
                n_checks++;
                if (fifo1.din_o !== prev_din) begin
                    n_fail++;
                    $display("FAIL din_hold_full: cycle %0d got %h expected %h", c, fifo1.din_o, prev_din);
                end
            end
            prev_din = fifo1.din_o;
            if (saved) saved_c = c;
            if (c == 1) ev = rand_evt();
            if (c == 2) rdy = 1'b0;
            if (c == pulse_at) begin
                rdy = 1'b1;
                ev  = nxt;
            end
            if (c == pulse_at + 3) rdy = 1'b0;
            fifo1.full_i = (c + 1 >= full_from) && (c + 1 <= full_to);
        end
    endtask

    task automatic test_reset();
        int busy_seen;
        aresetn = 1'b0;
        rdy = 1'b1; ev = '0; fifo1.full_i = 1'b0;
        rdy2 = 1'b0; ev2 = '0; fifo2.full_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (fifo1.wr_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", fifo1.wr_en_o); end
        n_checks++; if (fifo1.din_o !== '0) begin n_fail++; $display("FAIL reset_din: got %h expected 0", fifo1.din_o); end
        n_checks++; if (saved !== 1'b0) begin n_fail++; $display("FAIL reset_saved: got %b expected 0", saved); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (evt_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_evt_count: got %0d expected 0", evt_cnt); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d expected 0", drop_cnt); end
        @(negedge clk);
        aresetn = 1'b1;
        busy_seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (busy || fifo1.wr_en_o) busy_seen++;
        end
        n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL reset_held_ready_no_start: got %0d busy cycles expected 0", busy_seen); end
        @(negedge clk);
        rdy = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_single_event();
        logic [N*W-1:0] v;
        int fw, lw, nw, sc, g;
        logic [W-1:0] fd;
        for (int k = 0; k < N; k++) v[k*W +: W] = 64'h1000 + 64'(k);
        push_event(v, exp_evt, exp_drop);
        fire(v);
        collect(0, 60, 1000, 1000, 1000, '0, fw, lw, nw, sc, g, fd);
        exp_evt = exp_evt + 32'd1;
        n_checks++; if (fw !== 3) begin n_fail++; $display("FAIL single_first_write: got %0d expected 3", fw); end
        n_checks++; if (nw !== 17) begin n_fail++; $display("FAIL single_write_count: got %0d expected 17", nw); end
        n_checks++; if (lw !== 19) begin n_fail++; $display("FAIL single_last_write: got %0d expected 19", lw); end
        n_checks++; if (sc !== 20) begin n_fail++; $display("FAIL single_saved_cycle: got %0d expected 20", sc); end
        n_checks++; if (fd !== 64'hCAFE_0000_0000_0000) begin n_fail++; $display("FAIL single_header: got %h expected cafe000000000000", fd); end
        n_checks++; if (evt_cnt !== exp_evt) begin n_fail++; $display("FAIL single_evt_count: got %0d expected %0d", evt_cnt, exp_evt); end
        n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL single_leftover: got %0d words expected 0", q.size()); end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] v;
        int fw, lw, nw, sc, g;
        logic [W-1:0] fd;
        v = rand_evt();
        push_event(v, exp_evt, exp_drop);
        fire(v);
        collect(0, 60, 5, 9, 1000, '0, fw, lw, nw, sc, g, fd);
        exp_evt = exp_evt + 32'd1;
        n_checks++; if (g !== 0) begin n_fail++; $display("FAIL bp_write_while_full: got %0d expected 0", g); end
        n_checks++; if (nw !== 17) begin n_fail++; $display("FAIL bp_write_count: got %0d expected 17", nw); end
        n_checks++; if (lw !== 24) begin n_fail++; $display("FAIL bp_last_write: got %0d expected 24", lw); end
        n_checks++; if (sc !== 25) begin n_fail++; $display("FAIL bp_saved_cycle: got %0d expected 25", sc); end
        n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL bp_leftover: got %0d words expected 0", q.size()); end
    endtask

    task automatic test_drop();
        logic [N*W-1:0] v;
        int fw, lw, nw, sc, g;
        logic [W-1:0] fd;
        v = rand_evt();
        push_event(v, exp_evt, exp_drop);
        fire(v);
        collect(0, 60, 1000, 1000, 8, rand_evt(), fw, lw, nw, sc, g, fd);
        exp_evt  = exp_evt + 32'd1;
        exp_drop = exp_drop + 16'd1;
        n_checks++; if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL drop_count: got %0d expected %0d", drop_cnt, exp_drop); end
        n_checks++; if (nw !== 17 || sc !== 20) begin n_fail++; $display("FAIL drop_first_intact: got %0d writes saved %0d expected 17 writes saved 20", nw, sc); end
        v = rand_evt();
        push_event(v, exp_evt, exp_drop);
        fire(v);
        collect(0, 60, 1000, 1000, 1000, '0, fw, lw, nw, sc, g, fd);
        exp_evt = exp_evt + 32'd1;
        n_checks++; if (fd[47:32] !== 16'h0001) begin n_fail++; $display("FAIL drop_next_header: got %h expected 0001", fd[47:32]); end
        n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL drop_leftover: got %0d words expected 0", q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] v1, v2;
        int fw, lw, nw, sc, g;
        logic [W-1:0] fd;
        v1 = rand_evt();
        v2 = rand_evt();
        push_event(v1, exp_evt, exp_drop);
        push_event(v2, exp_evt + 32'd1, exp_drop);
        fire(v1);
        collect(0, 60, 1000, 1000, 18, v2, fw, lw, nw, sc, g, fd);
        n_checks++; if (sc !== 20) begin n_fail++; $display("FAIL b2b_first_saved: got %0d expected 20", sc); end
        collect(1, 60, 1000, 1000, 1000, '0, fw, lw, nw, sc, g, fd);
        exp_evt = exp_evt + 32'd2;
        n_checks++; if (fw !== 3 || nw !== 17) begin n_fail++; $display("FAIL b2b_second_timing: got first %0d count %0d expected first 3 count 17", fw, nw); end
        n_checks++; if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL b2b_no_drop: got %0d expected %0d", drop_cnt, exp_drop); end
        n_checks++; if (evt_cnt !== exp_evt) begin n_fail++; $display("FAIL b2b_evt_count: got %0d expected %0d", evt_cnt, exp_evt); end
        n_checks++; if (q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d words expected 0", q.size()); end
    endtask

    task automatic test_drop_in_done();
        logic [N*W-1:0] v;
        int fw, lw, nw, sc, g, busy_seen;
        logic [W-1:0] fd;
        v = rand_evt();
        push_event(v, exp_evt, exp_drop);
        fire(v);
        collect(0, 60, 1000, 1000, 17, rand_evt(), fw, lw, nw, sc, g, fd);
        exp_evt  = exp_evt + 32'd1;
        exp_drop = exp_drop + 16'd1;
        busy_seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (busy || fifo1.wr_en_o) busy_seen++;
        end
        n_checks++; if (drop_cnt !== exp_drop) begin n_fail++; $display("FAIL done_drop_count: got %0d expected %0d", drop_cnt, exp_drop); end
        n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL done_drop_no_start: got %0d busy cycles expected 0", busy_seen); end
    endtask

    task automatic test_reset_mid();
        logic [N*W-1:0] v;
        int fw, lw, nw, sc, g, wr_seen;
        logic [W-1:0] fd;
        v = rand_evt();
        push_event(v, exp_evt, exp_drop);
        fire(v);
        collect(0, 8, 1000, 1000, 1000, '0, fw, lw, nw, sc, g, fd);
        aresetn = 1'b0;
        #1;
        n_checks++; if (fifo1.wr_en_o !== 1'b0 || fifo1.din_o !== '0) begin n_fail++; $display("FAIL midrst_fifo_outputs: got wr_en %b din %h expected 0", fifo1.wr_en_o, fifo1.din_o); end
        n_checks++; if (busy !== 1'b0 || saved !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_saved: got %b %b expected 0 0", busy, saved); end
        n_checks++; if (evt_cnt !== 32'd0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_counters: got %0d %0d expected 0 0", evt_cnt, drop_cnt); end
        wr_seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (fifo1.wr_en_o) wr_seen++;
        end
        n_checks++; if (wr_seen !== 0) begin n_fail++; $display("FAIL midrst_writes: got %0d expected 0", wr_seen); end
        q.delete();
        exp_evt  = '0;
        exp_drop = '0;
        @(negedge clk);
        aresetn = 1'b1;
        repeat (4) @(posedge clk);
        v = rand_evt();
        push_event(v, exp_evt, exp_drop);
        fire(v);
        collect(0, 60, 1000, 1000, 1000, '0, fw, lw, nw, sc, g, fd);
        exp_evt = exp_evt + 32'd1;
        n_checks++; if (fd[31:0] !== 32'd0) begin n_fail++; $display("FAIL midrst_next_header_count: got %0d expected 0", fd[31:0]); end
        n_checks++; if (nw !== 17 || sc !== 20) begin n_fail++; $display("FAIL midrst_next_event: got %0d writes saved %0d expected 17 and 20", nw, sc); end
    endtask

    task automatic test_no_header();
        logic [N2*W2-1:0] v;
        int fw, lw, nw, sc;
        fw = -1; lw = -1; nw = 0; sc = -1;
        for (int i = 0; i < N2*W2/32; i++) v[i*32 +: 32] = $urandom();
        @(negedge clk);
        ev2  = v;
        rdy2 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            if (fifo2.wr_en_o) begin
                if (fw < 0) fw = c;
                lw = c;
                n_checks++;
                if (nw >= N2 || fifo2.din_o !== v[nw*W2 +: W2]) begin
                    n_fail++;
                    $display("FAIL nohdr_word: cycle %0d got %h expected word %0d", c, fifo2.din_o, nw);
                end
                nw++;
            end
            if (saved2 && sc < 0) sc = c;
            if (c == 1) ev2 = '1;
            if (c == 2) rdy2 = 1'b0;
        end
        n_checks++; if (nw !== 4) begin n_fail++; $display("FAIL nohdr_write_count: got %0d expected 4", nw); end
        n_checks++; if (fw !== 3 || lw !== 6) begin n_fail++; $display("FAIL nohdr_timing: got %0d..%0d expected 3..6", fw, lw); end
        n_checks++; if (sc !== 7) begin n_fail++; $display("FAIL nohdr_saved_cycle: got %0d expected 7", sc); end
        n_checks++; if (evt_cnt2 !== 32'd1) begin n_fail++; $display("FAIL nohdr_evt_count: got %0d expected 1", evt_cnt2); end
    endtask

    task automatic test_drop_saturation();
        fire(rand_evt());
        @(negedge clk);
        fifo1.full_i = 1'b1;
        repeat (3) @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        force dut.drop_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.drop_cnt;
        for (int p = 0; p < 2; p++) begin
            rdy = 1'b1;
            repeat (3) @(negedge clk);
            rdy = 1'b0;
            repeat (4) @(negedge clk);
            n_checks++; if (drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL drop_saturate_%0d: got %h expected ffff", p, drop_cnt); end
        end
        n_checks++; if (busy !== 1'b1 || fifo1.wr_en_o !== 1'b0) begin n_fail++; $display("FAIL drop_sat_held: got busy %b wr_en %b expected 1 0", busy, fifo1.wr_en_o); end
        aresetn = 1'b0;
        fifo1.full_i = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        q.delete();
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_drop_in_done();
        test_reset_mid();
        test_no_header();
        test_drop_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
